// File: rtl/cbfp_pkg.sv
`default_nettype none
// ============================================================================
// cbfp_pkg : default widths/targets and shift-amount type for cbfp_denorm
// Revision : 1.0
// ============================================================================
package cbfp_pkg;
  localparam int DEF_DIN_W        = 12;
  localparam int DEF_OUT_W        = 25;
  localparam int DEF_EXP_W        = 5;
  localparam int DEF_SHIFT_TARGET = 13;
  localparam int DEF_LANES        = 8;
  localparam int DEF_BLOCK_CYC    = 2;
  localparam int DEF_EXP_DEPTH    = 4;

  // Signed shift amount: one bit wider than the exponent so SHIFT_TARGET-exp fits
  typedef logic signed [DEF_EXP_W:0] shamt_t;
endpackage
`default_nettype wire

// File: rtl/cbfp_exp_fifo.sv
`default_nettype none
// ============================================================================
// cbfp_exp_fifo : synchronous FIFO for block shift values, same-cycle push/pop
// Revision      : 1.0
// ============================================================================
module cbfp_exp_fifo
  import cbfp_pkg::*;
#(
  parameter int WIDTH = DEF_EXP_W,
  parameter int DEPTH = DEF_EXP_DEPTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_pop;
  logic             w_do_push;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end
endmodule
`default_nettype wire

// File: rtl/cbfp_denorm.sv
`default_nettype none
// ============================================================================
// cbfp_denorm : inverse block-floating-point scaling of 8-lane I/Q samples
// Option      : CBFP_DENORM_SAT_EN selects left-shift saturation (else wrap)
// Revision    : 1.0
// ============================================================================
module cbfp_denorm
  import cbfp_pkg::*;
#(
  parameter int DIN_W        = DEF_DIN_W,
  parameter int OUT_W        = DEF_OUT_W,
  parameter int LANES        = DEF_LANES,
  parameter int EXP_W        = DEF_EXP_W,
  parameter int SHIFT_TARGET = DEF_SHIFT_TARGET,
  parameter int BLOCK_CYC    = DEF_BLOCK_CYC,
  parameter int EXP_DEPTH    = DEF_EXP_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   exp_valid,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic                   valid_in,
  input  logic [DIN_W*LANES-1:0] din_i,
  input  logic [DIN_W*LANES-1:0] din_q,
  output logic [OUT_W*LANES-1:0] dout_i,
  output logic [OUT_W*LANES-1:0] dout_q,
  output logic                   valid_out,
  output logic                   err_underflow,
  output logic                   err_overflow
);
  localparam int BW = (BLOCK_CYC > 1) ? $clog2(BLOCK_CYC) : 1;
`ifdef CBFP_DENORM_SAT_EN
  localparam int WIDE = (DIN_W + SHIFT_TARGET >= OUT_W) ? DIN_W + SHIFT_TARGET + 1 : OUT_W + 1;
`endif

  logic [BW-1:0]          r_blk_cnt;
  logic [EXP_W-1:0]       r_cur_exp;
  logic [OUT_W*LANES-1:0] r_dout_i;
  logic [OUT_W*LANES-1:0] r_dout_q;
  logic                   r_valid_out;
  logic                   r_err_underflow;
  logic                   r_err_overflow;

  logic                   w_start;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [EXP_W-1:0]       w_head;
  logic [EXP_W-1:0]       w_exp;
  shamt_t                 w_shamt;
  logic [OUT_W*LANES-1:0] w_dout_i;
  logic [OUT_W*LANES-1:0] w_dout_q;

  function automatic logic [OUT_W-1:0] denorm(input logic [DIN_W-1:0] d, input shamt_t s);
    logic [EXP_W:0] mag;
`ifdef CBFP_DENORM_SAT_EN
    logic signed [WIDE-1:0] w;
`else
    logic signed [OUT_W-1:0] w;
`endif
    mag = s[EXP_W] ? $unsigned(-s) : $unsigned(s);
`ifdef CBFP_DENORM_SAT_EN
    w = WIDE'($signed(d));
    w = s[EXP_W] ? (w >>> mag) : (w <<< mag);
    // Bits above the output sign must all match it, otherwise clamp by input sign
    if (!(&w[WIDE-1:OUT_W-1]) && (|w[WIDE-1:OUT_W-1]))
      return d[DIN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    return w[OUT_W-1:0];
`else
    w = OUT_W'($signed(d));
    w = s[EXP_W] ? (w >>> mag) : (w <<< mag);
    return w;
`endif
  endfunction

  cbfp_exp_fifo #(
    .WIDTH (EXP_W),
    .DEPTH (EXP_DEPTH)
  ) u_exp_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (exp_valid),
    .pop   (w_pop),
    .din   (exp_in),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // An empty FIFO at block start falls back to unity gain and leaves the FIFO untouched
  assign w_start = valid_in && (r_blk_cnt == '0);
  assign w_pop   = w_start && !w_empty;
  assign w_exp   = w_start ? (w_empty ? EXP_W'(SHIFT_TARGET) : w_head) : r_cur_exp;
  assign w_shamt = shamt_t'(SHIFT_TARGET) - shamt_t'({1'b0, w_exp});

  always_comb begin
    w_dout_i = '0;
    w_dout_q = '0;
    for (int k = 0; k < LANES; k++) begin
      w_dout_i[k*OUT_W +: OUT_W] = denorm(din_i[k*DIN_W +: DIN_W], w_shamt);
      w_dout_q[k*OUT_W +: OUT_W] = denorm(din_q[k*DIN_W +: DIN_W], w_shamt);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_blk_cnt       <= '0;
      r_cur_exp       <= EXP_W'(SHIFT_TARGET);
      r_dout_i        <= '0;
      r_dout_q        <= '0;
      r_valid_out     <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_overflow  <= 1'b0;
    end else begin
      r_valid_out <= valid_in;
      if (valid_in) begin
        r_dout_i  <= w_dout_i;
        r_dout_q  <= w_dout_q;
        r_blk_cnt <= (r_blk_cnt == BW'(BLOCK_CYC - 1)) ? '0 : r_blk_cnt + 1'b1;
      end
      if (w_start) r_cur_exp <= w_exp;
      if (w_start && w_empty) r_err_underflow <= 1'b1;
      if (exp_valid && w_full && !w_pop) r_err_overflow <= 1'b1;
    end
  end

  assign dout_i        = r_dout_i;
  assign dout_q        = r_dout_q;
  assign valid_out     = r_valid_out;
  assign err_underflow = r_err_underflow;
  assign err_overflow  = r_err_overflow;
endmodule
`default_nettype wire
